serial_to_parallel: RTL and testbench

- Deserializer that sits directly downstream of the team's 4-bit parallel-to-serial stage.
- Consumes a serial bit stream, LSB first, with a one-cycle frame-start marker and rebuilds WIDTH-bit words.
- Presents each word on a valid/ready output register, so downstream logic can stall without corrupting a frame in flight.
- Flags overrun and framing errors and counts delivered words.

---
 rtl/serial_to_parallel_if.sv | 27 ++
 rtl/serial_to_parallel.sv | 109 ++++++++++
 tb/tb_serial_to_parallel.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_to_parallel_if.sv
// Bundle of serial input, handshake and status signals for the deserializer.
// The bench or upstream logic drives through master; the deserializer attaches as slave.
interface serial_to_parallel_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             serial_i;
    logic             start_i;
    logic             out_ready_i;
    logic             clear_err_i;
    logic [WIDTH-1:0] parallel_o;
    logic             out_valid_o;
    logic             busy_o;
    logic             overrun_o;
    logic             frame_err_o;
    logic [CNT_W-1:0] word_count_o;

    modport master (
        output serial_i, start_i, out_ready_i, clear_err_i,
        input  parallel_o, out_valid_o, busy_o, overrun_o, frame_err_o, word_count_o
    );

    modport slave (
        input  serial_i, start_i, out_ready_i, clear_err_i,
        output parallel_o, out_valid_o, busy_o, overrun_o, frame_err_o, word_count_o
    );
endinterface

// File: rtl/serial_to_parallel.sv
// LSB-first deserializer with frame-start marker, valid/ready output register,
// sticky overrun/framing flags and a count of delivered words.
module serial_to_parallel #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_to_parallel_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    bit_cnt, cnt_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [WIDTH-1:0] assembled;
    logic [WIDTH-1:0] out_word;
    logic             out_valid;
    logic             overrun;
    logic             frame_err;
    logic [CNT_W-1:0] word_count;
    logic             word_done;
    logic             start_err;
    logic             drain;

    // New bits enter at the MSB and walk right, so bit 0 lands at position 0 last.
    assign assembled = (shift_reg >> 1) | {bus.serial_i, {(WIDTH-1){1'b0}}};
    assign drain     = out_valid && bus.out_ready_i;

    always_comb begin
        state_next = state;
        cnt_next   = bit_cnt;
        shift_next = shift_reg;
        word_done  = 1'b0;
        start_err  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start_i) begin
                    shift_next = {bus.serial_i, {(WIDTH-1){1'b0}}};
                    cnt_next   = CW'(1);
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.start_i) begin
                    start_err  = 1'b1;
                    shift_next = {bus.serial_i, {(WIDTH-1){1'b0}}};
                    cnt_next   = CW'(1);
                end else if (bit_cnt == CW'(WIDTH-1)) begin
                    word_done  = 1'b1;
                    shift_next = assembled;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    shift_next = assembled;
                    cnt_next   = bit_cnt + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            out_word   <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            word_count <= '0;
        end else begin
            state     <= state_next;
            bit_cnt   <= cnt_next;
            shift_reg <= shift_next;

            if (drain)
                word_count <= word_count + CNT_W'(1);

            // A finished word may reuse the register only if it is empty or emptying now.
            if (word_done && (!out_valid || drain)) begin
                out_word  <= assembled;
                out_valid <= 1'b1;
            end else if (drain) begin
                out_valid <= 1'b0;
            end

            if (word_done && out_valid && !bus.out_ready_i)
                overrun <= 1'b1;
            else if (bus.clear_err_i)
                overrun <= 1'b0;

            if (start_err)
                frame_err <= 1'b1;
            else if (bus.clear_err_i)
                frame_err <= 1'b0;
        end
    end

    assign bus.parallel_o   = out_word;
    assign bus.out_valid_o  = out_valid;
    assign bus.busy_o       = (state == SHIFT);
    assign bus.overrun_o    = overrun;
    assign bus.frame_err_o  = frame_err;
    assign bus.word_count_o = word_count;
endmodule

// File: tb/tb_serial_to_parallel.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// traffic compared every cycle against a queue-based reference model.
module tb_serial_to_parallel;
    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fails  = 0;
    bit   check_en = 1'b0;

    serial_to_parallel_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    serial_to_parallel #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a frame is just the list of bits seen since the last start.
    bit               m_bits[$];
    logic [WIDTH-1:0] m_data;
    bit               m_valid;
    logic [CNT_W-1:0] m_count;
    bit               m_ovr;
    bit               m_ferr;

    always @(posedge clk) begin
        bit               v0, drain, done, ovr_evt, ferr_evt;
        logic [WIDTH-1:0] word;
        if (reset) begin
            m_bits.delete();
            m_data   = '0;
            m_valid  = 1'b0;
            m_count  = '0;
            m_ovr    = 1'b0;
            m_ferr   = 1'b0;
            check_en = 1'b1;
        end else begin
            v0       = m_valid;
            drain    = v0 && bus.out_ready_i;
            done     = 1'b0;
            ovr_evt  = 1'b0;
            ferr_evt = 1'b0;
            word     = '0;
            if (bus.start_i) begin
                if (m_bits.size() > 0) ferr_evt = 1'b1;
                m_bits.delete();
                m_bits.push_back(bus.serial_i);
            end else if (m_bits.size() > 0) begin
                m_bits.push_back(bus.serial_i);
            end
            if (m_bits.size() == WIDTH) begin
                done = 1'b1;
                for (int i = 0; i < WIDTH; i++)
                    if (m_bits[i]) word = word + (WIDTH'(1) << i);
                m_bits.delete();
            end
            if (drain) m_count = m_count + 1'b1;
            if (done && (!v0 || drain)) begin
                m_data  = word;
                m_valid = 1'b1;
            end else begin
                if (done) ovr_evt = 1'b1;
                if (drain) m_valid = 1'b0;
            end
            if (ovr_evt) m_ovr = 1'b1;
            else if (bus.clear_err_i) m_ovr = 1'b0;
            if (ferr_evt) m_ferr = 1'b1;
            else if (bus.clear_err_i) m_ferr = 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en && !reset) begin
            checkOutput("model parallel_o", 32'(bus.parallel_o), 32'(m_data));
            checkOutput("model out_valid_o", 32'(bus.out_valid_o), 32'(m_valid));
            checkOutput("model busy_o", 32'(bus.busy_o), 32'(m_bits.size() > 0));
            checkOutput("model overrun_o", 32'(bus.overrun_o), 32'(m_ovr));
            checkOutput("model frame_err_o", 32'(bus.frame_err_o), 32'(m_ferr));
            checkOutput("model word_count_o", 32'(bus.word_count_o), 32'(m_count));
        end
    end

    task automatic applyStimulus(input bit start, input bit serial, input bit ready, input bit clear);
        @(negedge clk);
        bus.start_i     = start;
        bus.serial_i    = serial;
        bus.out_ready_i = ready;
        bus.clear_err_i = clear;
    endtask

    task automatic sendFrame(input logic [WIDTH-1:0] word, input bit ready);
        for (int i = 0; i < WIDTH; i++)
            applyStimulus(i == 0, word[i], ready, 1'b0);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset           = 1'b1;
        bus.start_i     = 1'b0;
        bus.serial_i    = 1'b0;
        bus.out_ready_i = 1'b0;
        bus.clear_err_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.start_i     = 1'b0;
        bus.serial_i    = 1'b0;
        bus.out_ready_i = 1'b0;
        bus.clear_err_i = 1'b0;

        doReset();
        checkOutput("reset valid", 32'(bus.out_valid_o), 32'd0);
        checkOutput("reset count", 32'(bus.word_count_o), 32'd0);

        // Single frame 1,0,1,1 LSB first -> 4'hD
        sendFrame(4'hD, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t1 parallel", 32'(bus.parallel_o), 32'hD);
        checkOutput("t1 valid", 32'(bus.out_valid_o), 32'd1);
        checkOutput("t1 busy after frame", 32'(bus.busy_o), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t1 count", 32'(bus.word_count_o), 32'd1);
        checkOutput("t1 valid drop", 32'(bus.out_valid_o), 32'd0);

        // Back-to-back D then 6
        doReset();
        sendFrame(4'hD, 1'b1);
        sendFrame(4'h6, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t2 parallel", 32'(bus.parallel_o), 32'h6);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t2 count", 32'(bus.word_count_o), 32'd2);
        checkOutput("t2 ferr", 32'(bus.frame_err_o), 32'd0);

        // Overrun with stalled output
        doReset();
        sendFrame(4'hA, 1'b0);
        sendFrame(4'h5, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t3 parallel held", 32'(bus.parallel_o), 32'hA);
        checkOutput("t3 overrun", 32'(bus.overrun_o), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t3 delivered", 32'(bus.word_count_o), 32'd1);
        checkOutput("t3 overrun cleared", 32'(bus.overrun_o), 32'd0);

        // Ready exactly on completion of second frame
        doReset();
        sendFrame(4'hA, 1'b0);
        for (int i = 0; i < WIDTH; i++)
            applyStimulus(i == 0, 1'(4'h5 >> i), i == WIDTH-1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t4 parallel", 32'(bus.parallel_o), 32'h5);
        checkOutput("t4 valid", 32'(bus.out_valid_o), 32'd1);
        checkOutput("t4 overrun", 32'(bus.overrun_o), 32'd0);
        checkOutput("t4 count", 32'(bus.word_count_o), 32'd1);

        // Restart mid-frame
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        sendFrame(4'h3, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t5 parallel", 32'(bus.parallel_o), 32'h3);
        checkOutput("t5 ferr", 32'(bus.frame_err_o), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t5 count", 32'(bus.word_count_o), 32'd1);

        // Reset mid-frame, then 9, then counter wrap
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        doReset();
        checkOutput("t6 busy after reset", 32'(bus.busy_o), 32'd0);
        checkOutput("t6 ferr after reset", 32'(bus.frame_err_o), 32'd0);
        sendFrame(4'h9, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t6 parallel", 32'(bus.parallel_o), 32'h9);
        for (int n = 1; n < 255; n++) sendFrame(WIDTH'(n), 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t6 count 255", 32'(bus.word_count_o), 32'd255);
        sendFrame(4'h1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t6 count wrap", 32'(bus.word_count_o), 32'd0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                doReset();
            end else begin
                applyStimulus($urandom_range(0, 5) == 0, 1'($urandom),
                              $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
            end
        end

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
